// File: rtl/path_dram_cmd_gen_if.sv
// Path-request, address-generator and DRAM-command signals of path_dram_cmd_gen.
// The master modport is the environment side; the slave modport is the command generator.
interface path_dram_cmd_gen_if #(
  parameter int ORAML      = 31,
  parameter int DDR_ADDR_W = 28
);
  // Handshakes: a transfer happens on a rising clock edge where valid and ready are both 1.
  // Once valid is raised, the payload stays stable until the transfer happens.
  logic                  PathValid;
  logic                  PathReady;
  logic [ORAML-1:0]      PathLeaf;
  logic                  PathOp;
  logic [ORAML-1:0]      AGLeaf;
  logic                  AGStart;
  logic                  AGEnable;
  logic [ORAML+1:0]      AGBktIdx;
  logic                  DRAMCommandValid;
  logic                  DRAMCommandReady;
  logic                  DRAMCommand;
  logic [DDR_ADDR_W-1:0] DRAMCommandAddress;
  logic                  PathDone;

  modport master (
    output PathValid, PathLeaf, PathOp, AGBktIdx, DRAMCommandReady,
    input  PathReady, AGLeaf, AGStart, AGEnable, DRAMCommandValid,
           DRAMCommand, DRAMCommandAddress, PathDone
  );

  modport slave (
    input  PathValid, PathLeaf, PathOp, AGBktIdx, DRAMCommandReady,
    output PathReady, AGLeaf, AGStart, AGEnable, DRAMCommandValid,
           DRAMCommand, DRAMCommandAddress, PathDone
  );
endinterface

// File: rtl/path_dram_cmd_gen.sv
// Walks one ORAM path root-to-leaf, turning each bucket index into BKT_BURSTS DRAM burst commands.
// Optional macro PATH_STALL_COUNT_EN adds the StallCycles output (saturating stall counter).
module path_dram_cmd_gen #(
  parameter int ORAML           = 31,
  parameter int BKT_BURSTS      = 4,
  parameter int BURST_ADDR_STEP = 8,
  parameter int DDR_ADDR_W      = 28
) (
  input  logic               Clock,
  input  logic               Reset,
  path_dram_cmd_gen_if.slave bus,
  output logic [1:0]         o_dbg_state
`ifdef PATH_STALL_COUNT_EN
  ,
  output logic [31:0]        StallCycles
`endif
);

  localparam int LW = $clog2(ORAML + 1);
  localparam int BW = (BKT_BURSTS > 1) ? $clog2(BKT_BURSTS) : 1;
  localparam int FW = ORAML + 2 + BW + $clog2(BURST_ADDR_STEP) + DDR_ADDR_W;

  typedef enum logic [1:0] {S_IDLE, S_INIT, S_ISSUE, S_DONE} state_t;

  state_t           r_state;
  logic [LW-1:0]    r_level;
  logic [BW-1:0]    r_burst;
  logic             r_ready;
  logic             r_start;
  logic             r_valid;
  logic             r_done;
  logic             r_op;
  logic [ORAML-1:0] r_leaf;

  logic                 w_accept;
  logic                 w_fire;
  logic                 w_last_burst;
  logic                 w_last_level;
  logic [FW-1:0]        w_full_addr;
  logic [FW-DDR_ADDR_W-1:0] w_unused_addr_hi;

  assign w_accept     = (r_state == S_IDLE) && r_ready && bus.PathValid;
  // Reset gates the handshake so AGEnable cannot pulse in the cycle reset is being applied.
  assign w_fire       = r_valid && bus.DRAMCommandReady && Reset;
  assign w_last_burst = (r_burst == BW'(BKT_BURSTS - 1));
  assign w_last_level = (r_level == LW'(ORAML));

  // Full-width product; only the low DDR_ADDR_W bits leave the block.
  assign w_full_addr = ((FW'(bus.AGBktIdx) * FW'(BKT_BURSTS)) + FW'(r_burst))
                       * FW'(BURST_ADDR_STEP);
  assign w_unused_addr_hi = w_full_addr[FW-1:DDR_ADDR_W];

  assign bus.PathReady          = r_ready;
  assign bus.AGLeaf             = r_leaf;
  assign bus.AGStart            = r_start;
  assign bus.AGEnable           = w_fire && w_last_burst && !w_last_level;
  assign bus.DRAMCommandValid   = r_valid;
  assign bus.DRAMCommand        = r_op;
  assign bus.DRAMCommandAddress = r_valid ? w_full_addr[DDR_ADDR_W-1:0] : '0;
  assign bus.PathDone           = r_done;
  assign o_dbg_state            = r_state;

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_state <= S_IDLE;
      r_level <= '0;
      r_burst <= '0;
      r_ready <= 1'b0;
      r_start <= 1'b0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_op    <= 1'b0;
      r_leaf  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_leaf  <= bus.PathLeaf;
            r_op    <= bus.PathOp;
            r_ready <= 1'b0;
            r_start <= 1'b1;
            r_level <= '0;
            r_burst <= '0;
            r_state <= S_INIT;
          end else begin
            r_ready <= 1'b1;
          end
        end
        S_INIT: begin
          r_start <= 1'b0;
          r_valid <= 1'b1;
          r_state <= S_ISSUE;
        end
        S_ISSUE: begin
          if (w_fire) begin
            if (w_last_burst) begin
              r_burst <= '0;
              if (w_last_level) begin
                r_valid <= 1'b0;
                r_done  <= 1'b1;
                r_state <= S_DONE;
              end else begin
                r_level <= r_level + 1'b1;
              end
            end else begin
              r_burst <= r_burst + 1'b1;
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef PATH_STALL_COUNT_EN
  logic [31:0] r_stall;

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_stall <= '0;
    end else if (w_accept) begin
      r_stall <= '0;
    end else if (r_valid && !bus.DRAMCommandReady && (r_stall != '1)) begin
      r_stall <= r_stall + 1'b1;
    end
  end

  assign StallCycles = r_stall;
`endif

endmodule

// File: tb/tb_path_dram_cmd_gen.sv
// Self-checking bench for path_dram_cmd_gen: stub address generator, ready shaping and a command scoreboard.
module tb_path_dram_cmd_gen;

  localparam int ORAML = 3;
  localparam int BB    = 2;
  localparam int STEP  = 8;
  localparam int AW    = 28;
  localparam int AW6   = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  path_dram_cmd_gen_if #(.ORAML(ORAML), .DDR_ADDR_W(AW))  ifa ();
  path_dram_cmd_gen_if #(.ORAML(ORAML), .DDR_ADDR_W(AW6)) ifb ();

  logic [1:0] dbg_a;
  logic [1:0] dbg_b;
`ifdef PATH_STALL_COUNT_EN
  logic [31:0] stall_a;
  logic [31:0] stall_b;
`endif

  path_dram_cmd_gen #(.ORAML(ORAML), .BKT_BURSTS(BB), .BURST_ADDR_STEP(STEP), .DDR_ADDR_W(AW)) u_dut (
    .Clock       (clk),
    .Reset       (rst_n),
    .bus         (ifa),
    .o_dbg_state (dbg_a)
`ifdef PATH_STALL_COUNT_EN
    ,
    .StallCycles (stall_a)
`endif
  );

  path_dram_cmd_gen #(.ORAML(ORAML), .BKT_BURSTS(BB), .BURST_ADDR_STEP(STEP), .DDR_ADDR_W(AW6)) u_dut6 (
    .Clock       (clk),
    .Reset       (rst_n),
    .bus         (ifb),
    .o_dbg_state (dbg_b)
`ifdef PATH_STALL_COUNT_EN
    ,
    .StallCycles (stall_b)
`endif
  );

  // ---------------- scoreboard state ----------------
  logic [AW:0]  exp_q[$];
  logic [AW6:0] exp6_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ag_mode = 0;
  int ag_tab[4] = '{0, 1, 4, 9};
  int acc_cnt = 0, en_cnt = 0, done_cnt = 0, start_cnt = 0, stall_obs = 0, n_acc = 0;
  int acc_cyc = 0, done_cyc = 0;
  int b_cmds = 0, b_done = 0, b_acc = 0;
  int stall_at = 1, stall_left = 0;
  bit rnd_ready = 0;
  bit done_flag = 0;
  bit leaf_pend = 0;
  logic [ORAML-1:0] leaf_exp;
  logic [1:0] lvl = '0;
  logic [ORAML+1:0] stub_idx;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [AW:0] exp_cmd(input int mode, input int l, input int b,
                                          input logic [ORAML-1:0] leaf, input logic op);
    logic [63:0] idx;
    logic [63:0] full;
    if (mode == 0) begin
      idx  = 64'(ag_tab[l]);
      full = (idx * BB + 64'(b)) * STEP;
    end else begin
      idx  = (64'd1 << l) - 1 + (64'(leaf) >> (ORAML - l));
      full = idx * 16 + 64'(b) * 8;
    end
    return {op, full[AW-1:0]};
  endfunction

  // ---------------- stub address generators ----------------
  always @(posedge clk) begin
    if (ifa.AGStart) lvl <= '0;
    else if (ifa.AGEnable) lvl <= lvl + 2'd1;
  end

  always_comb begin
    stub_idx = '0;
    if (ag_mode == 0) stub_idx = (ORAML+2)'(ag_tab[lvl]);
    else              stub_idx = (ORAML+2)'((32'd1 << lvl) - 1 + (32'(ifa.AGLeaf) >> (ORAML - int'(lvl))));
  end

  assign ifa.AGBktIdx = stub_idx;
  assign ifb.AGBktIdx = '1;
  assign ifb.DRAMCommandReady = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- ready shaping ----------------
  always @(posedge clk) begin
    #1;
    if (stall_left > 0 && ifa.DRAMCommandValid && acc_cnt == stall_at) begin
      ifa.DRAMCommandReady = 1'b0;
      stall_left--;
    end else if (rnd_ready) begin
      ifa.DRAMCommandReady = ($urandom_range(0, 3) != 0);
    end else begin
      ifa.DRAMCommandReady = 1'b1;
    end
  end

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    logic [AW:0] w;
    if (rst_n) begin
      if (leaf_pend) begin
        chk("agleaf", ifa.AGLeaf, leaf_exp);
        chk("agstart", ifa.AGStart, 1);
        leaf_pend = 0;
      end
      if (ifa.AGStart) start_cnt++;
      if (ifa.AGEnable) begin
        en_cnt++;
        chk("en_qual", ifa.DRAMCommandValid && ifa.DRAMCommandReady, 1);
      end
      if (ifa.PathDone) begin
        done_cnt++;
        done_cyc  = cyc;
        done_flag = 1;
      end
      if (ifa.DRAMCommandValid) begin
        if (exp_q.size() == 0) begin
          chk("cmd_unexp", ifa.DRAMCommandValid, 0);
        end else if (ifa.DRAMCommandReady) begin
          w = exp_q.pop_front();
          chk("cmd", {ifa.DRAMCommand, ifa.DRAMCommandAddress}, w);
          acc_cnt++;
        end else begin
          chk("hold", {ifa.DRAMCommand, ifa.DRAMCommandAddress}, exp_q[0]);
          stall_obs++;
        end
      end
      if (ifa.PathValid && ifa.PathReady) begin
        for (int l = 0; l <= ORAML; l++)
          for (int b = 0; b < BB; b++)
            exp_q.push_back(exp_cmd(ag_mode, l, b, ifa.PathLeaf, ifa.PathOp));
        acc_cyc   = cyc;
        leaf_exp  = ifa.PathLeaf;
        leaf_pend = 1;
        n_acc++;
      end
    end
  end

  always @(negedge clk) begin
    logic [63:0] full;
    if (rst_n) begin
      if (ifb.DRAMCommandValid && ifb.DRAMCommandReady) begin
        if (exp6_q.size() == 0) chk("b_unexp", ifb.DRAMCommandValid, 0);
        else chk("b_cmd", {ifb.DRAMCommand, ifb.DRAMCommandAddress}, exp6_q.pop_front());
        b_cmds++;
      end
      if (ifb.PathDone) b_done++;
      if (ifb.PathValid && ifb.PathReady) begin
        for (int l = 0; l <= ORAML; l++)
          for (int b = 0; b < BB; b++) begin
            full = (64'd31 * BB + 64'(b)) * STEP;
            exp6_q.push_back({ifb.PathOp, full[AW6-1:0]});
          end
        b_acc++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_acc(input int base, input string tag);
    int n = 0;
    while (n_acc == base && n < 60) begin
      @(posedge clk);
      n++;
    end
    chk(tag, n_acc - base, 1);
  endtask

  task automatic start_path(input logic [ORAML-1:0] leaf, input logic op);
    int base;
    @(posedge clk);
    #1;
    done_flag = 0;
    base = n_acc;
    ifa.PathValid = 1'b1;
    ifa.PathLeaf  = leaf;
    ifa.PathOp    = op;
    wait_acc(base, "acc_to");
    #1;
    ifa.PathValid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done_flag && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk("done_to", done_flag, 1);
  endtask

  task automatic clr_counts();
    acc_cnt = 0; en_cnt = 0; done_cnt = 0; start_cnt = 0; stall_obs = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base, d1, n;
    ifa.PathValid = 1'b0; ifa.PathLeaf = '0; ifa.PathOp = 1'b0;
    ifb.PathValid = 1'b0; ifb.PathLeaf = '0; ifb.PathOp = 1'b0;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", ifa.PathReady, 0);
    chk("rst_valid", ifa.DRAMCommandValid, 0);
    chk("rst_start", ifa.AGStart, 0);
    chk("rst_en", ifa.AGEnable, 0);
    chk("rst_done", ifa.PathDone, 0);
    chk("rst_addr", ifa.DRAMCommandAddress, 0);
    chk("rst_leaf", ifa.AGLeaf, 0);
    chk("rst_state", dbg_a, 0);
`ifdef PATH_STALL_COUNT_EN
    chk("rst_stall", stall_a, 0);
`endif
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("ready_after_rst", ifa.PathReady, 1);

    // A: table generator, read path, ready always high
    ag_mode = 0; clr_counts();
    start_path(3'd6, 1'b0);
    wait_done(100);
    chk("A_lat", done_cyc - acc_cyc, 10);
    chk("A_en", en_cnt, 3);
    chk("A_cmds", acc_cnt, 8);
    chk("A_q", exp_q.size(), 0);
    @(negedge clk);
    chk("A_done_pulse", ifa.PathDone, 0);

    // B: write path, 3-cycle stall on the second command
    clr_counts(); stall_at = 1; stall_left = 3;
    start_path(3'd1, 1'b1);
    wait_done(100);
    chk("B_lat", done_cyc - acc_cyc, 13);
    chk("B_stall_obs", stall_obs, 3);
    chk("B_cmds", acc_cnt, 8);
    chk("B_q", exp_q.size(), 0);
`ifdef PATH_STALL_COUNT_EN
    chk("B_stallcnt", stall_a, 3);
`endif

    // C: PathValid held across two paths
    clr_counts();
    @(posedge clk); #1;
    done_flag = 0;
    base = n_acc;
    ifa.PathValid = 1'b1; ifa.PathLeaf = 3'd5; ifa.PathOp = 1'b0;
    wait_acc(base, "C_acc1");
    #1 ifa.PathLeaf = 3'd2;
    base = n_acc;
    wait_acc(base, "C_acc2");
    d1 = done_cyc;
    chk("C_b2b", acc_cyc - d1, 1);
    #1 ifa.PathValid = 1'b0;
    done_flag = 0;
    wait_done(100);
    chk("C_cmds", acc_cnt, 16);
    chk("C_en", en_cnt, 6);
    chk("C_dones", done_cnt, 2);
    chk("C_q", exp_q.size(), 0);

    // D: reset right after the third command is accepted
    clr_counts();
    start_path(3'd3, 1'b0);
    n = 0;
    while (acc_cnt < 3 && n < 60) begin
      @(posedge clk);
      n++;
    end
    chk("D_third", acc_cnt, 3);
    #1 rst_n = 1'b0;
    en_cnt = 0; done_cnt = 0; start_cnt = 0;
    exp_q.delete();
    @(posedge clk); @(negedge clk);
    chk("D_valid", ifa.DRAMCommandValid, 0);
    chk("D_ready", ifa.PathReady, 0);
    chk("D_state", dbg_a, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("D_ready_after", ifa.PathReady, 1);
    repeat (5) @(posedge clk);
    chk("D_nodone", done_cnt, 0);
    chk("D_noen", en_cnt, 0);
    chk("D_nostart", start_cnt, 0);
    clr_counts();
    start_path(3'd4, 1'b1);
    wait_done(100);
    chk("D_restart", start_cnt, 1);
    chk("D_cmds", acc_cnt, 8);
    chk("D_q", exp_q.size(), 0);

    // E: heap-ordered generator, random leaves and random ready
    ag_mode = 1; rnd_ready = 1;
    for (int p = 0; p < 4; p++) begin
      clr_counts();
      start_path(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      wait_done(400);
      chk("E_cmds", acc_cnt, 8);
      chk("E_en", en_cnt, 3);
      chk("E_q", exp_q.size(), 0);
`ifdef PATH_STALL_COUNT_EN
      chk("E_stallcnt", stall_a, stall_obs);
`endif
    end
    rnd_ready = 0;

    // F: 6-bit address truncation
    @(posedge clk); #1;
    ifb.PathValid = 1'b1; ifb.PathOp = 1'b1; ifb.PathLeaf = 3'd7;
    n = 0;
    while (b_acc == 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    chk("F_acc", b_acc, 1);
    #1 ifb.PathValid = 1'b0;
    n = 0;
    while (b_done == 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    chk("F_done", b_done, 1);
    chk("F_cmds", b_cmds, 8);
    chk("F_q", exp6_q.size(), 0);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/path_dram_cmd_gen.md
Name: path_dram_cmd_gen

Overview:
- Downstream consumer of the bucket-head address generator. Walks one ORAM path root-to-leaf and turns each bucket's starting index into a stream of DRAM burst commands.
- Drives the generator's Start/Enable and reads its bucket index back. Issues BKT_BURSTS commands per bucket over a valid/ready channel to the DRAM command interface.
- One path (read or write) per accepted request. Signals completion with a one-cycle done pulse.

Parameters:
ORAML, 31, tree depth; path has ORAML+1 buckets; leaf width ORAML
BKT_BURSTS, 4, DRAM bursts per bucket (power of two, >=1)
BURST_ADDR_STEP, 8, DRAM address units per burst (power of two)
DDR_ADDR_W, 28, DRAM command address width

Ports:
Clock  in  1  system clock
Reset  in  1  synchronous, active-low reset (Reset==0 resets)
PathValid  in  1  path request valid
PathReady  out  1  ready to accept path request
PathLeaf  in  ORAML  leaf label of requested path
PathOp  in  1  0=read path, 1=write path
AGLeaf  out  ORAML  leaf to address generator (registered)
AGStart  out  1  address generator start pulse
AGEnable  out  1  address generator advance-level pulse
AGBktIdx  in  ORAML+2  current bucket index from generator
DRAMCommandValid  out  1  command valid
DRAMCommandReady  in  1  command accepted
DRAMCommand  out  1  0=read, 1=write (= latched PathOp)
DRAMCommandAddress  out  DDR_ADDR_W  burst address
PathDone  out  1  one-cycle pulse after last command accepted

Behaviour:
- States: IDLE, INIT, ISSUE, DONE. Reset (Reset==0) forces:
  - state IDLE, level counter 0, burst counter 0;
  - PathReady=0 during reset, 1 in IDLE after reset;
  - all other outputs 0.
- IDLE:
  - PathReady=1.
  - On PathValid&PathReady: latch PathLeaf into AGLeaf and PathOp into the op register; go to INIT.
  - PathReady=0 in every other state.
- INIT: AGStart=1 for exactly this cycle; go to ISSUE. AGBktIdx is valid from the next cycle.
- ISSUE:
  - DRAMCommandValid=1.
  - DRAMCommandAddress = ((AGBktIdx*BKT_BURSTS)+burstCnt)*BURST_ADDR_STEP. Computed at full width, then truncated to the low DDR_ADDR_W bits.
  - Address and command held stable while Valid&!Ready.
  - On each Valid&Ready: burstCnt++.
  - On the last burst of a bucket (burstCnt==BKT_BURSTS-1):
    - burstCnt wraps to 0;
    - if level==ORAML, go to DONE;
    - else AGEnable=1 in that same cycle, level++, stay in ISSUE. The next bucket's first command is issued the following cycle, with no bubble.
  - AGEnable is never asserted except on an accepted last burst.
- DONE: PathDone=1 for one cycle; go to IDLE.
- Per path:
  - exactly (ORAML+1)*BKT_BURSTS commands;
  - AGEnable pulses exactly ORAML times;
  - minimum path latency from accept to PathDone is 2+(ORAML+1)*BKT_BURSTS cycles.
- PathValid asserted outside IDLE is ignored (not accepted, no state change).
- Reset mid-path: abandons immediately. Valid drops the same cycle reset is sampled; no PathDone; no further AGStart/AGEnable.
- Back-to-back: a new request may be accepted in the cycle after DONE.

Optional Feature:
- Macro: PATH_STALL_COUNT_EN.
- Defined:
  - adds output StallCycles, 32 bits;
  - counts cycles with DRAMCommandValid&!DRAMCommandReady;
  - saturates at 2^32-1;
  - cleared to 0 by reset and on each path accept;
  - held after PathDone until the next accept.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- ORAML=3, BKT_BURSTS=2, STEP=8, stub AG returning 0,1,4,9 per level, Ready always 1, PathOp=0 -> addresses 0,8,16,24,64,72,144,152 with DRAMCommand=0; AGEnable pulses 3 times; PathDone in cycle 10 after accept.
- Same setup, PathOp=1, Ready low 3 cycles on the 2nd command -> address 8 held for 4 cycles; order unchanged; with PATH_STALL_COUNT_EN, StallCycles=3 at PathDone.
- PathValid held high continuously over two paths, leafs 5 then 2 -> AGLeaf=5 then 2; second accept in the cycle after PathDone; 16 commands total.
- Reset asserted after the 3rd command accepted -> Valid=0 that cycle; no PathDone; PathReady=1 in the cycle after reset deasserts; new path restarts with AGStart.
- Stub AG returning index 2^(ORAML+2)-1 with DDR_ADDR_W=6 -> address equals the low 6 bits of the full product (truncation, no overflow flag).
- Real address generator with ORAML=3 and any leaf -> commands match the model's BktIdx*16+b*8 for levels 0..3.
